lc3_kbd_port: RTL and testbench
===============================

# lc3_kbd_port

Memory-mapped keyboard-style input device for the LC-3 core, the input-side counterpart of the seven-segment/LED output path. It synchronizes and debounces the board push-button (`btn`), captures an 8-bit switch value on each debounced press, and presents it to the CPU through the standard LC-3 KBSR/KBDR register pair. It raises an interrupt request when enabled. It sits on the LC-3 memory bus beside main memory, and the core's address decoder selects it when `mem_hit` is set.

## Interface
- `DEBOUNCE_CYCLES`, 4: consecutive stable cycles required to accept a level change; legal range 1..255.
- `KBSR_ADDR`, 16'hFE00: status register address.
- `KBDR_ADDR`, 16'hFE02: data register address.

- `clk_0` input 1: sole clock; all state updates on rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `btn` input 1: raw, asynchronous push-button.
- `sw` input 8: raw, asynchronous switch bank; this is the character value.
- `mem_addr` input 16: bus address.
- `mem_en` input 1: bus access strobe, one cycle per access.
- `mem_we` input 1: 1 = write, 0 = read.
- `mem_wdata` input 16: write data.
- `mem_rdata` output 16: read data, combinational.
- `mem_hit` output 1: combinational; 1 when `mem_addr` equals `KBSR_ADDR` or `KBDR_ADDR`, regardless of `mem_en`.
- `irq` output 1: registered interrupt request.

## Operation
- **Synchronizers:** `btn` and `sw` each pass through a 2-flop synchronizer, giving `btn_s` and `sw_s`.
- **Debounce counter:**
  - `stable` holds the accepted button level; `cnt` is 8 bits.
  - On an edge where `btn_s == stable`, `cnt` <= 0.
  - On an edge where `btn_s != stable` and `cnt == DEBOUNCE_CYCLES-1`: `stable` <= `btn_s` and `cnt` <= 0.
  - On any other edge where `btn_s != stable`: `cnt` increments.
- **Press event:** the edge on which `stable` goes 0->1. Release (1->0) produces no event.
- **Press capture:**
  - If `ready`=0 at the press edge: KBDR[7:0] <= `sw_s` and `ready` <= 1.
  - If `ready`=1 at the press edge: the data is dropped and `ovr` <= 1.
- **KBSR read value:** {`ready`, `ie`, `ovr`, 13'b0}.
- **KBDR read value:** {8'b0, `kbdr`}.
- **Read, KBDR** (`mem_en`=1, `mem_we`=0, KBDR address): `ready` <= 0 at the edge.
- **Read, KBSR:** `ovr` <= 0 at the edge.
- **Read, any other address:** `mem_rdata` = 16'h0000 and no side effects.
- **Write, KBSR:** `ie` <= `mem_wdata[14]`. All other KBSR bits are read-only.
- **Write, KBDR:** ignored.
- **Interrupt:** `irq` <= `ready & ie`, registered.
- **Simultaneous read of KBDR and accepted press on the same edge:**
  - The read returns the old `kbdr`.
  - The new value is loaded and `ready` stays 1; the press wins.
  - `ovr` is not set.
- **Simultaneous read of KBSR and overrun press:** `ovr` ends at 1; set wins over clear.
- **Simultaneous KBSR write and interrupt update:** `irq` on the next edge uses the old `ie`; the new `ie` takes effect one edge later.

## Timing
- **Reset values** (asynchronous): all synchronizer flops, `stable`, `cnt`, `kbdr`, `ready`, `ie`, `ovr` and `irq` = 0. With `mem_en`=0, `mem_rdata` = 16'h0000.
- **Press latency:** with `btn` held high, let edge e0 be the first edge sampling 1.
  - `btn_s`=1 after e1.
  - `stable`, `ready` and `kbdr` update at edge e(DEBOUNCE_CYCLES+1).
  - `irq` rises one edge later.
  - For the default of 4: `ready` at e5, `irq` at e6.
- **Glitch rejection:** a `btn` pulse shorter than DEBOUNCE_CYCLES synchronized cycles is never accepted. Any return of `btn_s` to `stable` restarts the count.
- **Switch stability:** `sw` must be stable for 2 cycles before the press edge; `sw_s` is the value captured.
- **Read data:** valid in the same cycle as `mem_en`, combinational from the registers.
- **Read side effects:** take place at the closing edge of the access cycle.
- **Mid-operation reset:** asserting `rst` mid-debounce or with `ready`=1 clears everything immediately. A button still held after release of reset must be re-accepted: after DEBOUNCE_CYCLES+2 edges it generates a new press.

## Test plan
- **Reset:** `rst`=0 with `btn`=1 and `sw`=8'h5A -> all outputs 0. Release reset, `btn` still held -> `ready`=1 at e5 (DEBOUNCE_CYCLES=4) and KBDR reads 16'h005A.
- **Glitch rejection:** `btn` high for 2 cycles, then low -> `ready` stays 0 and KBSR reads 16'h0000.
- **Normal press and interrupt:**
  - Write KBSR with 16'h4000, then press with `sw`=8'h41 -> KBSR reads 16'hC000 and `irq`=1 one edge after `ready`.
  - Read KBDR -> returns 16'h0041; `ready`=0 after the edge and `irq`=0 one edge later.
- **Overrun:**
  - Two presses without a read (`sw`=8'h31, then 8'h32) -> KBDR = 16'h0031 and KBSR = 16'hA000.
  - KBSR read -> next KBSR read = 16'h8000.
- **Collision:** KBDR read on the same edge as an accepted press with `sw`=8'h77 -> the read returns the old data, then `ready`=1, KBDR = 16'h0077, `ovr`=0.
- **Address decode:** access 16'hFE04 -> `mem_hit`=0, `mem_rdata`=0, no state change. Write 16'hFFFF to KBDR -> KBDR unchanged.

Source files
------------

// File: rtl/lc3_kbd_port_if.sv
// LC-3 memory bus bundle seen by the keyboard port: address/strobe/write-data in, read-data/hit out.
// Latency: none; pure signal grouping.
// Backpressure: none; the bus completes every access in a single cycle.
interface lc3_kbd_port_if;
  logic [15:0] mem_addr;
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_hit;

  // CPU side drives the access, device answers with data and decode hit
  modport master (
    output mem_addr, mem_en, mem_we, mem_wdata,
    input  mem_rdata, mem_hit
  );

  modport slave (
    input  mem_addr, mem_en, mem_we, mem_wdata,
    output mem_rdata, mem_hit
  );
endinterface

// File: rtl/lc3_kbd_port.sv
// LC-3 KBSR/KBDR input device: debounced push-button captures the switch bank as a character.
// Latency: press visible DEBOUNCE_CYCLES+2 edges after btn rises; read data combinational; irq +1 edge.
// Backpressure: none on the bus; a press arriving while a character is pending is dropped and flags overrun.
module lc3_kbd_port #(
  parameter int          DEBOUNCE_CYCLES = 4,
  parameter logic [15:0] KBSR_ADDR       = 16'hFE00,
  parameter logic [15:0] KBDR_ADDR       = 16'hFE02
) (
  input  logic        clk_0,
  input  logic        rst,
  input  logic        btn,
  input  logic [7:0]  sw,
  lc3_kbd_port_if.slave bus,
  output logic        irq
);

  localparam logic [7:0] CNT_MAX = 8'(DEBOUNCE_CYCLES - 1);

  logic       btn_m, btn_s;
  logic [7:0] sw_m, sw_s;
  logic       stable;
  logic [7:0] cnt;
  logic [7:0] kbdr;
  logic       ready, ie, ovr;

  logic hit_kbsr, hit_kbdr;
  logic rd_kbsr, rd_kbdr, wr_kbsr;
  logic press, accept, overrun;
  logic unused_wdata;

  // Bus decode; hit is independent of the strobe so the core's decoder can steer early
  assign hit_kbsr     = (bus.mem_addr == KBSR_ADDR);
  assign hit_kbdr     = (bus.mem_addr == KBDR_ADDR);
  assign bus.mem_hit  = hit_kbsr | hit_kbdr;
  assign rd_kbsr      = bus.mem_en & ~bus.mem_we & hit_kbsr;
  assign rd_kbdr      = bus.mem_en & ~bus.mem_we & hit_kbdr;
  assign wr_kbsr      = bus.mem_en &  bus.mem_we & hit_kbsr;
  assign unused_wdata = ^{bus.mem_wdata[15], bus.mem_wdata[13:0]};

  // A press is the edge on which the accepted level flips 0->1
  assign press = (btn_s != stable) && (cnt == CNT_MAX) && btn_s;
  // A KBDR read on the press edge frees the slot, so the new character is taken, not dropped
  assign accept  = press & (~ready | rd_kbdr);
  assign overrun = press & ready & ~rd_kbdr;

  // Two-flop synchronizers for the raw button and switch bank
  always_ff @(posedge clk_0 or negedge rst) begin
    if (!rst) begin
      btn_m <= 1'b0;
      btn_s <= 1'b0;
      sw_m  <= '0;
      sw_s  <= '0;
    end else begin
      btn_m <= btn;
      btn_s <= btn_m;
      sw_m  <= sw;
      sw_s  <= sw_m;
    end
  end

  // Debounce: any return to the accepted level restarts the count
  always_ff @(posedge clk_0 or negedge rst) begin
    if (!rst) begin
      stable <= 1'b0;
      cnt    <= '0;
    end else if (btn_s == stable) begin
      cnt <= '0;
    end else if (cnt == CNT_MAX) begin
      stable <= btn_s;
      cnt    <= '0;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

  // Character capture and ready flag; press wins over a same-edge KBDR read
  always_ff @(posedge clk_0 or negedge rst) begin
    if (!rst) begin
      kbdr  <= '0;
      ready <= 1'b0;
    end else if (accept) begin
      kbdr  <= sw_s;
      ready <= 1'b1;
    end else if (rd_kbdr) begin
      ready <= 1'b0;
    end
  end

  // Overrun flag: set wins over the clear-on-KBSR-read
  always_ff @(posedge clk_0 or negedge rst) begin
    if (!rst) begin
      ovr <= 1'b0;
    end else if (overrun) begin
      ovr <= 1'b1;
    end else if (rd_kbsr) begin
      ovr <= 1'b0;
    end
  end

  // Interrupt enable is the only writable KBSR bit
  always_ff @(posedge clk_0 or negedge rst) begin
    if (!rst) begin
      ie <= 1'b0;
    end else if (wr_kbsr) begin
      ie <= bus.mem_wdata[14];
    end
  end

  // Registered interrupt request; a same-edge ie write lands one edge later
  always_ff @(posedge clk_0 or negedge rst) begin
    if (!rst) begin
      irq <= 1'b0;
    end else begin
      irq <= ready & ie;
    end
  end

  // Combinational read mux; unmapped or idle cycles read as zero
  always_comb begin
    bus.mem_rdata = 16'h0000;
    if (bus.mem_en && !bus.mem_we) begin
      if (hit_kbsr) begin
        bus.mem_rdata = {ready, ie, ovr, 13'b0};
      end else if (hit_kbdr) begin
        bus.mem_rdata = {8'h00, kbdr};
      end
    end
  end

endmodule

// File: tb/tb_lc3_kbd_port.sv
// Self-checking bench for lc3_kbd_port: expected characters are queued at press time and
// popped when the CPU side reads KBDR; status/irq expectations are constants per scenario.
// Runs a fixed number of cycles; no open-ended waits.
module tb_lc3_kbd_port;

  localparam logic [15:0] KBSR = 16'hFE00;
  localparam logic [15:0] KBDR = 16'hFE02;

  logic       clk_0 = 1'b0;
  logic       rst   = 1'b0;
  logic       btn   = 1'b0;
  logic [7:0] sw    = 8'h00;
  logic       irq;

  lc3_kbd_port_if bus ();

  lc3_kbd_port #(
    .DEBOUNCE_CYCLES(4),
    .KBSR_ADDR(16'hFE00),
    .KBDR_ADDR(16'hFE02)
  ) dut (
    .clk_0(clk_0),
    .rst(rst),
    .btn(btn),
    .sw(sw),
    .bus(bus.slave),
    .irq(irq)
  );

  always #5 clk_0 = ~clk_0;

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0]  exp_q[$];
  logic [15:0] exp_kbdr;

  // advance one rising edge, then settle just past it
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_0);
      #1;
    end
  endtask

  // combinational look at a register without letting an edge close the access
  task automatic peek(input logic [15:0] addr, output logic [15:0] data);
    bus.mem_addr = addr;
    bus.mem_we   = 1'b0;
    bus.mem_en   = 1'b1;
    #1;
    data = bus.mem_rdata;
    bus.mem_en   = 1'b0;
    #1;
  endtask

  // full read cycle: data sampled mid-cycle, side effects at the closing edge
  task automatic bus_read(input logic [15:0] addr, output logic [15:0] data);
    bus.mem_addr = addr;
    bus.mem_we   = 1'b0;
    bus.mem_en   = 1'b1;
    #1;
    data = bus.mem_rdata;
    tick(1);
    bus.mem_en   = 1'b0;
  endtask

  task automatic bus_write(input logic [15:0] addr, input logic [15:0] data);
    bus.mem_addr  = addr;
    bus.mem_wdata = data;
    bus.mem_we    = 1'b1;
    bus.mem_en    = 1'b1;
    tick(1);
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
  endtask

  // hold the button long enough to be accepted, then release and let it settle low
  task automatic press(input logic [7:0] val);
    sw  = val;
    btn = 1'b1;
    tick(8);
    btn = 1'b0;
    tick(8);
  endtask

  task automatic test_reset;
    logic [15:0] d;
    rst = 1'b0;
    btn = 1'b1;
    sw  = 8'h5A;
    bus.mem_addr = 16'h0000;
    tick(3);
    n_checks++;
    if (irq !== 1'b0) $display("FAIL reset_irq got %b want 0", irq); else n_pass++;
    n_checks++;
    if (bus.mem_rdata !== 16'h0000) $display("FAIL reset_rdata got %h want 0000", bus.mem_rdata); else n_pass++;
    peek(KBSR, d);
    n_checks++;
    if (d !== 16'h0000) $display("FAIL reset_kbsr got %h want 0000", d); else n_pass++;
    // release between edges; next edge is e0 and the held button must be re-accepted at e5
    rst = 1'b1;
    exp_q.push_back(8'h5A);
    for (int k = 1; k <= 6; k++) begin
      tick(1);
      peek(KBSR, d);
      n_checks++;
      if (d !== ((k == 6) ? 16'h8000 : 16'h0000))
        $display("FAIL reset_ready_e%0d got %h want %h", k - 1, d, (k == 6) ? 16'h8000 : 16'h0000);
      else n_pass++;
    end
    bus_read(KBDR, d);
    exp_kbdr = {8'h00, exp_q.pop_front()};
    n_checks++;
    if (d !== exp_kbdr) $display("FAIL reset_kbdr got %h want %h", d, exp_kbdr); else n_pass++;
    btn = 1'b0;
    tick(8);
  endtask

  task automatic test_glitch;
    logic [15:0] d;
    sw  = 8'hEE;
    btn = 1'b1;
    tick(2);
    btn = 1'b0;
    tick(10);
    peek(KBSR, d);
    n_checks++;
    if (d !== 16'h0000) $display("FAIL glitch_kbsr got %h want 0000", d); else n_pass++;
    n_checks++;
    if (irq !== 1'b0) $display("FAIL glitch_irq got %b want 0", irq); else n_pass++;
  endtask

  task automatic test_press_irq;
    logic [15:0] d;
    bus_write(KBSR, 16'h4000);
    sw  = 8'h41;
    btn = 1'b1;
    exp_q.push_back(8'h41);
    tick(6);
    peek(KBSR, d);
    n_checks++;
    if (d !== 16'hC000) $display("FAIL press_kbsr got %h want C000", d); else n_pass++;
    n_checks++;
    if (irq !== 1'b0) $display("FAIL press_irq_early got %b want 0", irq); else n_pass++;
    tick(1);
    n_checks++;
    if (irq !== 1'b1) $display("FAIL press_irq got %b want 1", irq); else n_pass++;
    bus_read(KBDR, d);
    exp_kbdr = {8'h00, exp_q.pop_front()};
    n_checks++;
    if (d !== exp_kbdr) $display("FAIL press_kbdr got %h want %h", d, exp_kbdr); else n_pass++;
    peek(KBSR, d);
    n_checks++;
    if (d !== 16'h4000) $display("FAIL press_ready_clr got %h want 4000", d); else n_pass++;
    n_checks++;
    if (irq !== 1'b1) $display("FAIL press_irq_hold got %b want 1", irq); else n_pass++;
    tick(1);
    n_checks++;
    if (irq !== 1'b0) $display("FAIL press_irq_clr got %b want 0", irq); else n_pass++;
    btn = 1'b0;
    tick(8);
    bus_write(KBSR, 16'h0000);
  endtask

  task automatic test_overrun;
    logic [15:0] d;
    exp_q.push_back(8'h31);
    press(8'h31);
    press(8'h32);
    peek(KBDR, d);
    exp_kbdr = {8'h00, exp_q[0]};
    n_checks++;
    if (d !== exp_kbdr) $display("FAIL ovr_kbdr got %h want %h", d, exp_kbdr); else n_pass++;
    bus_read(KBSR, d);
    n_checks++;
    if (d !== 16'hA000) $display("FAIL ovr_kbsr got %h want A000", d); else n_pass++;
    peek(KBSR, d);
    n_checks++;
    if (d !== 16'h8000) $display("FAIL ovr_clr got %h want 8000", d); else n_pass++;
  endtask

  task automatic test_collision;
    logic [15:0] d;
    sw  = 8'h77;
    btn = 1'b1;
    tick(5);
    // this read's closing edge is the press edge
    bus_read(KBDR, d);
    exp_kbdr = {8'h00, exp_q.pop_front()};
    exp_q.push_back(8'h77);
    n_checks++;
    if (d !== exp_kbdr) $display("FAIL coll_old got %h want %h", d, exp_kbdr); else n_pass++;
    peek(KBSR, d);
    n_checks++;
    if (d !== 16'h8000) $display("FAIL coll_kbsr got %h want 8000", d); else n_pass++;
    btn = 1'b0;
    tick(8);
    bus_read(KBDR, d);
    exp_kbdr = {8'h00, exp_q.pop_front()};
    n_checks++;
    if (d !== exp_kbdr) $display("FAIL coll_new got %h want %h", d, exp_kbdr); else n_pass++;
  endtask

  task automatic test_decode;
    logic [15:0] d;
    bus.mem_en   = 1'b0;
    bus.mem_addr = KBSR;
    #1;
    n_checks++;
    if (bus.mem_hit !== 1'b1) $display("FAIL hit_kbsr got %b want 1", bus.mem_hit); else n_pass++;
    bus.mem_addr = KBDR;
    #1;
    n_checks++;
    if (bus.mem_hit !== 1'b1) $display("FAIL hit_kbdr got %b want 1", bus.mem_hit); else n_pass++;
    bus.mem_addr = 16'hFE04;
    bus.mem_en   = 1'b1;
    #1;
    n_checks++;
    if (bus.mem_hit !== 1'b0) $display("FAIL hit_fe04 got %b want 0", bus.mem_hit); else n_pass++;
    bus_read(16'hFE04, d);
    n_checks++;
    if (d !== 16'h0000) $display("FAIL rd_fe04 got %h want 0000", d); else n_pass++;
    bus_write(16'hFE04, 16'h4000);
    bus_write(KBDR, 16'hFFFF);
    peek(KBDR, d);
    n_checks++;
    if (d !== 16'h0077) $display("FAIL kbdr_wr got %h want 0077", d); else n_pass++;
    peek(KBSR, d);
    n_checks++;
    if (d !== 16'h0000) $display("FAIL decode_kbsr got %h want 0000", d); else n_pass++;
  endtask

  task automatic test_mid_reset;
    logic [15:0] d;
    sw  = 8'h99;
    btn = 1'b1;
    tick(3);
    rst = 1'b0;
    #1;
    peek(KBSR, d);
    n_checks++;
    if (d !== 16'h0000) $display("FAIL midrst_kbsr got %h want 0000", d); else n_pass++;
    tick(2);
    rst = 1'b1;
    exp_q.push_back(8'h99);
    tick(6);
    bus_read(KBDR, d);
    exp_kbdr = {8'h00, exp_q.pop_front()};
    n_checks++;
    if (d !== exp_kbdr) $display("FAIL midrst_kbdr got %h want %h", d, exp_kbdr); else n_pass++;
    btn = 1'b0;
    tick(8);
  endtask

  initial begin
    bus.mem_addr  = 16'h0000;
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_wdata = 16'h0000;
    test_reset();
    test_glitch();
    test_press_irq();
    test_overrun();
    test_collision();
    test_decode();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
